tm1640_frame_ctrl: RTL and testbench

TM1640_FRAME_CTRL -- requirements
Module: tm1640_frame_ctrl

---
 rtl/tm1640_frame_ctrl_pkg.sv | 56 +++++
 rtl/tm1640_frame_ctrl.sv | 114 +++++++++++
 tb/tb_tm1640_frame_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm1640_frame_ctrl_pkg.sv
// Shared constants, state encoding and frame byte table for the TM1640 frame controller.
package tm1640_frame_ctrl_pkg;

    localparam logic [7:0]  CMD_DATA_AUTO = 8'h40;
    localparam logic [7:0]  CMD_ADDR0     = 8'hC0;
    localparam logic [7:0]  CMD_DISP      = 8'h80;
    localparam int unsigned DISP_ON_BIT   = 3;
    localparam int unsigned FRAME_LEN     = 19;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        WAIT_HI,
        XFER,
        DONE
    } state_t;

    typedef struct packed {
        logic       stop;
        logic [7:0] data;
    } frame_byte_t;

    // Byte and stop flag for frame position idx; positions past the frame yield zero.
    function automatic frame_byte_t frame_byte(
        input logic [4:0]   idx,
        input logic [127:0] seg,
        input logic [2:0]   bright,
        input logic         disp_on
    );
        frame_byte_t fb;
        logic [3:0]  grid;
        fb   = '0;
        grid = idx[3:0] - 4'd2;
        case (idx)
            5'd0: begin
                fb.stop = 1'b1;
                fb.data = CMD_DATA_AUTO;
            end
            5'd1: fb.data = CMD_ADDR0;
            5'd18: begin
                fb.stop              = 1'b1;
                fb.data              = CMD_DISP;
                fb.data[DISP_ON_BIT] = disp_on;
                fb.data[2:0]         = bright;
            end
            default: begin
                if (idx >= 5'd2 && idx <= 5'd17) begin
                    fb.data = seg[{grid, 3'b000} +: 8];
                    fb.stop = (idx == 5'd17);
                end
            end
        endcase
        return fb;
    endfunction

endpackage

// File: rtl/tm1640_frame_ctrl.sv
// Sequences one 19-byte TM1640 display frame into a byte serializer per refresh request.
module tm1640_frame_ctrl
    import tm1640_frame_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         refresh,
    input  logic [127:0] seg_data,
    input  logic [2:0]   brightness,
    input  logic         disp_on,
    input  logic         busy,
    output logic         data_latch,
    output logic [7:0]   data_in,
    output logic         data_stop_bit,
    output logic         frame_busy,
    output logic         frame_done
);

    state_t       state, state_nxt;
    logic [4:0]   idx;
    logic [127:0] snap_seg;
    logic [2:0]   snap_bright;
    logic         snap_on;
    logic         wire_stop;
    logic         busy_q;
    logic         pending;
    logic         tick;
    logic         start;
    logic         busy_fall;
    logic         advance;
    frame_byte_t  cur;

    generate
        if (REFRESH_DIV == 0) begin : g_no_auto
            assign tick = 1'b0;
        end else begin : g_auto
            logic [31:0] refresh_cnt;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    refresh_cnt <= '0;
                else if (refresh_cnt == REFRESH_DIV - 1)
                    refresh_cnt <= '0;
                else
                    refresh_cnt <= refresh_cnt + 32'd1;
            end
            assign tick = (refresh_cnt == REFRESH_DIV - 1);
        end
    endgenerate

    assign start     = (state == IDLE) && pending;
    assign busy_fall = busy_q && !busy;
    // Chained bytes are pulled in by the serializer itself, so only the index moves.
    assign advance   = (state == LATCH) || (state == XFER && busy_fall && !wire_stop);
    assign cur       = frame_byte(idx, snap_seg, snap_bright, snap_on);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending) state_nxt = LATCH;
            LATCH:   state_nxt = WAIT_HI;
            WAIT_HI: if (busy) state_nxt = XFER;
            XFER: begin
                if (busy_fall && wire_stop)
                    state_nxt = (idx == 5'(FRAME_LEN)) ? DONE : LATCH;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx         <= '0;
            snap_seg    <= '0;
            snap_bright <= '0;
            snap_on     <= 1'b0;
            wire_stop   <= 1'b0;
            busy_q      <= 1'b0;
            pending     <= 1'b0;
        end else begin
            busy_q <= busy;
            if (start)
                pending <= 1'b0;
            else if (refresh || tick)
                pending <= 1'b1;
            if (start) begin
                snap_seg    <= seg_data;
                snap_bright <= brightness;
                snap_on     <= disp_on;
                idx         <= '0;
            end else if (advance) begin
                wire_stop <= cur.stop;
                idx       <= idx + 5'd1;
            end
        end
    end

    // Byte outputs are gated to zero outside a frame so reset and idle present 0x00.
    always_comb begin
        data_latch    = (state == LATCH);
        frame_done    = (state == DONE);
        frame_busy    = (state != IDLE);
        data_in       = (state != IDLE) ? cur.data : '0;
        data_stop_bit = (state != IDLE) ? cur.stop : 1'b0;
    end

endmodule

// File: tb/tb_tm1640_frame_ctrl.sv
// Directed bench for tm1640_frame_ctrl with a behavioural TM1640 byte serializer attached.
module tb_tm1640_frame_ctrl;

    localparam int BYTE_CYC = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         refresh = 1'b0;
    logic [127:0] seg_data = '0;
    logic [2:0]   brightness = 3'd0;
    logic         disp_on = 1'b0;
    logic         busy;
    logic         data_latch;
    logic [7:0]   data_in;
    logic         data_stop_bit;
    logic         frame_busy;
    logic         frame_done;

    logic         rst_a = 1'b1;
    logic         a_busy;
    logic         a_latch;
    logic [7:0]   a_din;
    logic         a_stop;
    logic         a_fbusy;
    logic         a_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tm1640_frame_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .refresh       (refresh),
        .seg_data      (seg_data),
        .brightness    (brightness),
        .disp_on       (disp_on),
        .busy          (busy),
        .data_latch    (data_latch),
        .data_in       (data_in),
        .data_stop_bit (data_stop_bit),
        .frame_busy    (frame_busy),
        .frame_done    (frame_done)
    );

    tm1640_frame_ctrl #(.REFRESH_DIV(5000)) u_auto (
        .clk           (clk),
        .rst           (rst_a),
        .refresh       (1'b0),
        .seg_data      ('0),
        .brightness    (3'd2),
        .disp_on       (1'b1),
        .busy          (a_busy),
        .data_latch    (a_latch),
        .data_in       (a_din),
        .data_stop_bit (a_stop),
        .frame_busy    (a_fbusy),
        .frame_done    (a_done)
    );

    // Serializer model: latch starts a byte; a byte without stop reloads data_in at its end.
    logic [7:0] sr_byte;
    logic       sr_stop;
    logic       reload;
    int         cnt;
    logic [7:0] sb[$];
    logic       ss[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0; reload <= 1'b0; cnt <= 0; sr_byte <= '0; sr_stop <= 1'b0;
        end else if (data_latch) begin
            sr_byte <= data_in; sr_stop <= data_stop_bit; busy <= 1'b1; cnt <= BYTE_CYC;
        end else if (reload) begin
            busy <= 1'b1; cnt <= BYTE_CYC; reload <= 1'b0;
        end else if (busy) begin
            if (cnt == 1) begin
                busy <= 1'b0;
                sb.push_back(sr_byte);
                ss.push_back(sr_stop);
                if (!sr_stop) begin
                    sr_byte <= data_in; sr_stop <= data_stop_bit; reload <= 1'b1;
                end
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    logic [7:0] a_byte_r;
    logic [7:0] a_last;
    logic       a_stop_r;
    logic       a_reload;
    int         a_cnt;

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            a_busy <= 1'b0; a_reload <= 1'b0; a_cnt <= 0; a_stop_r <= 1'b0;
            a_byte_r <= '0; a_last <= '0;
        end else if (a_latch) begin
            a_byte_r <= a_din; a_stop_r <= a_stop; a_busy <= 1'b1; a_cnt <= BYTE_CYC;
        end else if (a_reload) begin
            a_busy <= 1'b1; a_cnt <= BYTE_CYC; a_reload <= 1'b0;
        end else if (a_busy) begin
            if (a_cnt == 1) begin
                a_busy <= 1'b0;
                a_last <= a_byte_r;
                if (!a_stop_r) begin
                    a_byte_r <= a_din; a_stop_r <= a_stop; a_reload <= 1'b1;
                end
            end else begin
                a_cnt <= a_cnt - 1;
            end
        end
    end

    int latch_cnt = 0;
    int done_cnt = 0;
    int viol_latch = 0;
    int viol_stab = 0;
    logic busy_p = 1'b0;
    logic [7:0] din_p = '0;

    always @(posedge clk) begin
        if (rst) begin
            if (data_latch) latch_cnt++;
            if (frame_done) done_cnt++;
            if (data_latch && busy) viol_latch++;
            if (busy && busy_p && data_in !== din_p) viol_stab++;
        end
        if (rst_a && a_latch && a_busy) viol_latch++;
        busy_p <= busy;
        din_p  <= data_in;
    end

    int cyc = 0;
    int starts[3];
    int nstart = 0;
    int a_done_cnt = 0;
    logic a_fb_p = 1'b0;

    always @(posedge clk) begin
        if (rst_a) begin
            if (a_fbusy && !a_fb_p && nstart < 3) begin
                starts[nstart] = cyc;
                nstart++;
            end
            if (a_done) a_done_cnt++;
        end
        a_fb_p <= a_fbusy;
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_refresh();
        @(posedge clk); #1 refresh = 1'b1;
        @(posedge clk); #1 refresh = 1'b0;
    endtask

    task automatic wait_dones(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, done_cnt, target);
    endtask

    task automatic wait_bytes(input int target);
        int n = 0;
        while (sb.size() < target && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int base;
        int d0;
        int l0;
        int n;
        logic [7:0]  e;
        logic [18:0] sv;

        #1 rst = 1'b0; rst_a = 1'b0;
        #1;
        check("rst_latch", data_latch, 0);
        check("rst_fbusy", frame_busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_din", data_in, 8'h00);
        check("rst_stop", data_stop_bit, 0);
        @(negedge clk); rst = 1'b1; rst_a = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("idle_no_frame", frame_busy, 0);

        // Frame with grid n = n+1, brightness 5, display on
        for (int i = 0; i < 16; i++) seg_data[8*i +: 8] = 8'(i + 1);
        brightness = 3'd5; disp_on = 1'b1;
        base = sb.size(); d0 = done_cnt; l0 = latch_cnt;
        @(posedge clk); #1 refresh = 1'b1;
        @(posedge clk); #1 refresh = 1'b0;
        check("lat_after_1", data_latch, 0);
        @(posedge clk); #1;
        check("lat_after_2", data_latch, 1);
        check("first_din", data_in, 8'h40);
        check("first_stop", data_stop_bit, 1);
        check("fbusy_on", frame_busy, 1);
        wait_dones(d0 + 1, "f1_done");
        check("f1_len", sb.size() - base, 19);
        if (sb.size() - base >= 19) begin
            for (int i = 0; i < 19; i++) begin
                e = (i == 0) ? 8'h40 : (i == 1) ? 8'hC0 : (i == 18) ? 8'h8D : 8'(i - 1);
                check($sformatf("f1_byte%0d", i), sb[base + i], e);
                sv[i] = ss[base + i];
            end
            check("f1_stops", sv, 19'h60001);
        end
        check("f1_latches", latch_cnt - l0, 3);
        repeat (20) @(posedge clk);
        #1 check("f1_one_done", done_cnt, d0 + 1);
        check("f1_fbusy_off", frame_busy, 0);

        // Display off, max brightness
        disp_on = 1'b0; brightness = 3'd7;
        base = sb.size(); d0 = done_cnt;
        pulse_refresh();
        wait_dones(d0 + 1, "f2_done");
        check("f2_len", sb.size() - base, 19);
        if (sb.size() - base >= 19) begin
            check("f2_first", sb[base], 8'h40);
            check("f2_last", sb[base + 18], 8'h87);
        end

        // Coalesced requests and snapshot isolation
        for (int i = 0; i < 16; i++) seg_data[8*i +: 8] = 8'(8'hA0 + i);
        disp_on = 1'b1; brightness = 3'd3;
        base = sb.size(); d0 = done_cnt;
        pulse_refresh();
        wait_bytes(base + 5);
        for (int i = 0; i < 16; i++) seg_data[8*i +: 8] = 8'(8'h50 + i);
        pulse_refresh();
        repeat (20) @(posedge clk);
        pulse_refresh();
        repeat (20) @(posedge clk);
        pulse_refresh();
        wait_dones(d0 + 2, "f3_two_done");
        repeat (400) @(posedge clk);
        #1 check("f3_no_third", done_cnt, d0 + 2);
        check("f3_len", sb.size() - base, 38);
        if (sb.size() - base >= 38) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("f3a_grid%0d", i), sb[base + 2 + i], 8'(8'hA0 + i));
                check($sformatf("f3b_grid%0d", i), sb[base + 21 + i], 8'(8'h50 + i));
            end
            check("f3b_first", sb[base + 19], 8'h40);
            check("f3b_last", sb[base + 37], 8'h8B);
        end

        // Reset in the middle of the grid bytes
        base = sb.size(); d0 = done_cnt;
        pulse_refresh();
        wait_bytes(base + 8);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_fbusy", frame_busy, 0);
        check("mid_rst_latch", data_latch, 0);
        check("mid_rst_din", data_in, 8'h00);
        check("mid_rst_stop", data_stop_bit, 0);
        check("mid_rst_done", frame_done, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("rst_no_done", done_cnt, d0);
        base = sb.size();
        pulse_refresh();
        wait_dones(d0 + 1, "f4_done");
        check("f4_len", sb.size() - base, 19);
        if (sb.size() - base >= 19) begin
            check("f4_first", sb[base], 8'h40);
            check("f4_grid0", sb[base + 2], 8'h50);
            check("f4_last", sb[base + 18], 8'h8B);
        end

        // Auto-refresh instance spacing
        n = 0;
        while (nstart < 3 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check("auto_starts", nstart, 3);
        if (nstart >= 3) begin
            check("auto_gap1", starts[1] - starts[0], 5000);
            check("auto_gap2", starts[2] - starts[1], 5000);
        end
        repeat (300) @(posedge clk);
        #1 check("auto_dones", (a_done_cnt >= 3) ? 1 : 0, 1);
        check("auto_last_byte", a_last, 8'h8A);

        check("latch_while_busy", viol_latch, 0);
        check("din_stable", viol_stab, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
